ram_program_loader: RTL
=======================

// Module: ram_program_loader
// PURPOSE
//   Boot-time stage directly upstream of the computer's RAM and core. Takes a framed byte
//   stream (SYNC, LEN, LEN data bytes, optional checksum) on a valid/ready port and writes
//   it into RAM from address 0. The core is held in reset until a frame loads cleanly.
//   In silicon this replaces the simulation-only hex preload; the out_val checks are unchanged.
// PARAMETERS
//   DATA_WIDTH      8     RAM word width; stream bytes are DATA_WIDTH bits
//   ADDR_WIDTH      4     RAM address width; DEPTH = 2**ADDR_WIDTH
//   SYNC_BYTE       8'hA5 frame start marker
//   TIMEOUT_CYCLES  1000  max idle cycles between bytes inside a frame; 0 disables timeout
// PORTS
//   clk         in   1           system clock, rising edge
//   reset       in   1           asynchronous, active-low reset
//   in_data     in   DATA_WIDTH  stream byte
//   in_valid    in   1           in_data valid
//   in_ready    out  1           loader accepts; byte taken when in_valid & in_ready at posedge
//   ram_we      out  1           RAM write strobe, one cycle per data byte
//   ram_addr    out  ADDR_WIDTH  RAM write address
//   ram_wdata   out  DATA_WIDTH  RAM write data
//   cpu_hold    out  1           1 = keep core in reset
//   load_done   out  1           frame loaded and verified; sticky until next SYNC
//   load_error  out  1           frame rejected; sticky until next SYNC
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0,
//     cpu_hold=1, load_done=0, load_error=0, byte count=0, checksum=0, timer=0.
//   in_ready=1 in every state once reset is released. No backpressure; 1 byte/cycle max.
//   FSM (advances only on an accepted byte, except for timeout):
//     IDLE : byte==SYNC_BYTE -> LEN, clear sum/count; any other byte is discarded.
//     LEN  : L = byte. L==0 or L>DEPTH -> ERROR; otherwise latch L -> DATA.
//     DATA : write byte to addr=count; sum += byte (mod 2**DATA_WIDTH); count++.
//            After the L-th byte: -> CSUM if LOADER_CHECKSUM_EN, else -> DONE.
//     CSUM : byte==sum -> DONE, else -> ERROR.
//     DONE : load_done=1, cpu_hold=0. A SYNC byte -> LEN; sets cpu_hold=1, clears load_done.
//     ERROR: load_error=1, cpu_hold=1. A SYNC byte -> LEN; clears load_error.
//     Non-SYNC bytes are ignored in DONE/ERROR.
//   Write timing: data byte accepted at edge k -> ram_we=1 with that addr/data during
//     cycle k..k+1, registered. ram_we is high for exactly one cycle per byte.
//     Back-to-back bytes give back-to-back strobes.
//   ram_addr/ram_wdata hold their last value when ram_we=0.
//   Addresses >= L are left untouched (no RAM clear).
//   Timeout: in LEN/DATA/CSUM the timer counts cycles with no accepted byte.
//     Timer reaches TIMEOUT_CYCLES -> ERROR. Timer resets to 0 on every accepted byte.
//     No timeout in IDLE/DONE/ERROR.
//   A SYNC_BYTE value inside LEN/DATA/CSUM is treated as ordinary data (no resync).
//   Async reset mid-frame aborts the frame: state=IDLE, cpu_hold=1.
//     RAM contents already written are not restored.
//   cpu_hold deasserts the cycle after entering DONE.
//     The core then starts from its own reset state: PC=0.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: the frame carries a trailing checksum byte.
//     CSUM state is present; a mismatch gives load_error.
//   Not defined: no checksum byte; DONE is entered right after the L-th data byte.
//     The CSUM state and the sum register are compiled out.
// TESTING
//   1 Reset: hold reset=0 for 3 cycles -> cpu_hold=1, ram_we=0, load_done=0, load_error=0,
//     in_ready=0. After release, in_ready=1.
//   2 Happy path (CHECKSUM_EN): send A5,03,11,22,33,66 ->
//     3 ram_we pulses: (0,11),(1,22),(2,33); load_done=1; cpu_hold=0.
//     Then the LDB program runs to halt with register B = 8'h11.
//   3 Bad checksum: send A5,02,01,02,04 -> 2 writes, then load_error=1, cpu_hold stays 1.
//     Re-sending a good frame recovers: load_error=0, load_done=1.
//   4 Length bounds (ADDR_WIDTH=4): LEN=00 -> ERROR; LEN=11h (17) -> ERROR, no writes.
//     LEN=10h with 16 data bytes -> addresses 0..F written, no wrap.
//   5 Timeout (TIMEOUT_CYCLES=20): A5,04,AA then idle 20 cycles -> load_error=1.
//     Idling 19 cycles then sending the next byte -> no error.
//   6 Garbage, then reset mid-frame: 00,FF,A5,02,7E -> one write (0,7E).
//     Reset pulse, then state=IDLE, cpu_hold=1, next byte 7E discarded.

Source files
------------

// File: rtl/ram_program_loader.sv
// ram_program_loader: boot-time loader between a framed byte stream and the core's RAM.
// Frame: SYNC_BYTE, LEN, LEN data bytes written from address 0, optional checksum byte.
// The core is held in reset (cpu_hold=1) until a frame has loaded cleanly.
// Build option: define LOADER_CHECKSUM_EN to expect a trailing checksum byte
// (sum of the data bytes mod 2**DATA_WIDTH). Without it, DONE follows the last data byte.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for SYNC_BYTE, other bytes discarded
// ST_LEN   | next byte is the frame length L (1..DEPTH accepted)
// ST_DATA  | writing data bytes to addresses 0..L-1
// ST_CSUM  | next byte is compared against the running sum (checksum builds only)
// ST_DONE  | frame loaded, core released; SYNC restarts a load
// ST_ERROR | frame rejected, core held; SYNC restarts a load

module ram_program_loader #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                    TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    // Timer is a down-counter loaded with TIMEOUT_CYCLES-1 on every accepted byte;
    // an idle edge that finds it at zero is the TIMEOUT_CYCLES-th idle edge.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t          state;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`endif

    logic accept;
    logic len_bad;
    logic last_byte;
    logic in_frame;

    assign accept    = in_valid & in_ready;
    assign len_bad   = (in_data == '0) || (32'(in_data) > 32'(DEPTH));
    assign last_byte = (count == len_q - CW'(1));

    // Timeout only applies while a frame is in flight.
    always_comb begin
        in_frame = 1'b0;
        case (state)
            ST_LEN, ST_DATA: in_frame = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM:         in_frame = 1'b1;
`endif
            default:         in_frame = 1'b0;
        endcase
    end

    // Frame sequencing, RAM write strobe and status flags, all registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            len_q      <= '0;
            count      <= '0;
            timer      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            in_ready <= 1'b1;
            ram_we   <= 1'b0;
            if (accept) begin
                timer <= TC_LOAD;
                case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (in_data == SYNC_BYTE) begin
                            state      <= ST_LEN;
                            count      <= '0;
                            cpu_hold   <= 1'b1;
                            load_done  <= 1'b0;
                            load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            sum        <= '0;
`endif
                        end
                    end
                    ST_LEN: begin
                        if (len_bad) begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end else begin
                            len_q <= CW'(in_data);
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        ram_we    <= 1'b1;
                        ram_addr  <= count[ADDR_WIDTH-1:0];
                        ram_wdata <= in_data;
                        count     <= count + CW'(1);
`ifdef LOADER_CHECKSUM_EN
                        sum       <= sum + in_data;
                        if (last_byte) state <= ST_CSUM;
`else
                        if (last_byte) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (in_data == sum) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end else if (TO_EN && in_frame) begin
                if (timer == '0) begin
                    state      <= ST_ERROR;
                    load_error <= 1'b1;
                    cpu_hold   <= 1'b1;
                end else begin
                    timer <= timer - TW'(1);
                end
            end
        end
    end

endmodule
